// File: rtl/mem_if_pkg.sv
// Shared definitions for the controller-to-memory interface: address field
// layout, bank count, responder state encoding and default device timings.
package mem_if_pkg;

    localparam int ROW_LSB   = 17;
    localparam int ROW_W     = 15;
    localparam int BANK_LSB  = 13;
    localparam int BANK_W    = 4;
    localparam int COL_LSB   = 3;
    localparam int COL_W     = 10;
    localparam int NUM_BANKS = 16;
    localparam int DATA_W    = 256;

    localparam int DEF_T_RCD  = 3;
    localparam int DEF_T_CL   = 4;
    localparam int DEF_T_WR   = 2;
    localparam int DEF_T_RP   = 3;
    localparam int DEF_T_RFC  = 8;
    localparam int DEF_T_REFI = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRECHARGE,
        ST_ACTIVATE,
        ST_ACCESS,
        ST_DONE,
        ST_REFRESH
    } mem_state_e;

    // The IDLE cycle that classifies a request counts as the first cycle of
    // the first phase, so that phase is loaded one shorter than later ones.
    function automatic logic [15:0] phase_load(input int cycles, input logic first);
        return first ? 16'(cycles - 2) : 16'(cycles - 1);
    endfunction

endpackage

// File: rtl/mem_storage_array.sv
// Single-port synchronous data store with a registered (read-first) output.
module mem_storage_array #(
    parameter int AW = 8,
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] index,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/mem_device_responder.sv
// Memory-device-side responder: per-bank open-row timing model, periodic
// refresh, and an on-chip data array behind a single-beat request interface.
module mem_device_responder
    import mem_if_pkg::*;
#(
    parameter int AW     = 8,
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_CL   = DEF_T_CL,
    parameter int T_WR   = DEF_T_WR,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_RFC  = DEF_T_RFC,
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       mem_addr,
    input  logic              mem_read_req,
    input  logic              mem_write_req,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    input  logic              inj_err_en,
    input  logic [7:0]        inj_err_bit,
    output logic [15:0]       stat_row_hits,
    output logic [15:0]       stat_row_misses,
    output logic              proto_err,
    output logic              busy
);

    mem_state_e state_reg, state_next;
    logic [15:0] count_reg, count_next;
    logic [15:0] timer_reg;
    logic        refresh_pending_reg;

    logic             bank_open_reg [NUM_BANKS];
    logic [ROW_W-1:0] bank_row_reg  [NUM_BANKS];

    logic              req_write_reg;
    logic [BANK_W-1:0] req_bank_reg;
    logic [ROW_W-1:0]  req_row_reg;
    logic [AW-1:0]     req_index_reg;

    logic [DATA_W-1:0] mem_rdata_reg;
    logic [15:0]       hits_reg, misses_reg;
    logic              proto_err_reg;

    logic              req_present, req_write;
    logic [ROW_W-1:0]  addr_row;
    logic [BANK_W-1:0] addr_bank;
    logic [COL_W-1:0]  addr_col;
    logic [BANK_W+COL_W-1:0] full_index;
    logic [AW-1:0]     addr_index, array_index;
    logic              row_hit, bank_open;
    logic              classify, do_precharge, do_activate, do_refresh, drop;
    logic              capture_read, array_we, addr_unused;
    logic [DATA_W-1:0] array_rdata, flip_mask;

    assign req_present = mem_read_req | mem_write_req;
    assign req_write   = mem_write_req;
    assign addr_row    = mem_addr[ROW_LSB +: ROW_W];
    assign addr_bank   = mem_addr[BANK_LSB +: BANK_W];
    assign addr_col    = mem_addr[COL_LSB +: COL_W];
    assign full_index  = {addr_bank, addr_col};
    assign addr_index  = full_index[AW-1:0];
    assign addr_unused = ^{mem_addr[2:0], full_index};

    assign bank_open = bank_open_reg[addr_bank];
    assign row_hit   = bank_open && (bank_row_reg[addr_bank] == addr_row);

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        classify     = 1'b0;
        do_precharge = 1'b0;
        do_activate  = 1'b0;
        do_refresh   = 1'b0;
        drop         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (refresh_pending_reg) begin
                    state_next = ST_REFRESH;
                    count_next = 16'(T_RFC - 1);
                    do_refresh = 1'b1;
                end else if (req_present) begin
                    classify = 1'b1;
                    if (row_hit) begin
                        state_next = ST_ACCESS;
                        count_next = phase_load(req_write ? T_WR : T_CL, 1'b1);
                    end else if (!bank_open) begin
                        state_next = ST_ACTIVATE;
                        count_next = phase_load(T_RCD, 1'b1);
                    end else begin
                        state_next = ST_PRECHARGE;
                        count_next = phase_load(T_RP, 1'b1);
                    end
                end
            end
            ST_PRECHARGE, ST_ACTIVATE, ST_ACCESS: begin
                if (!req_present) begin
                    state_next = ST_IDLE;
                    drop       = 1'b1;
                end else if (count_reg != 16'd0) begin
                    count_next = count_reg - 16'd1;
                end else if (state_reg == ST_PRECHARGE) begin
                    state_next   = ST_ACTIVATE;
                    count_next   = phase_load(T_RCD, 1'b0);
                    do_precharge = 1'b1;
                end else if (state_reg == ST_ACTIVATE) begin
                    state_next  = ST_ACCESS;
                    count_next  = phase_load(req_write_reg ? T_WR : T_CL, 1'b0);
                    do_activate = 1'b1;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_REFRESH: begin
                if (count_reg == 16'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    count_next = count_reg - 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign capture_read = (state_reg == ST_ACCESS) && (state_next == ST_DONE) && !req_write_reg;
    assign array_we     = (state_reg == ST_DONE) && req_write_reg;
    // The array is addressed from the live bus while classifying so its
    // registered output is already valid in the first ACCESS cycle.
    assign array_index  = (state_reg == ST_IDLE) ? addr_index : req_index_reg;
    assign flip_mask    = inj_err_en ? (DATA_W'(1) << inj_err_bit) : '0;

    mem_storage_array #(.AW(AW), .DW(DATA_W)) u_array (
        .clk   (clk),
        .we    (array_we),
        .index (array_index),
        .wdata (mem_wdata),
        .rdata (array_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= ST_IDLE;
            count_reg           <= '0;
            timer_reg           <= '0;
            refresh_pending_reg <= 1'b0;
            req_write_reg       <= 1'b0;
            req_bank_reg        <= '0;
            req_row_reg         <= '0;
            req_index_reg       <= '0;
            mem_rdata_reg       <= '0;
            hits_reg            <= '0;
            misses_reg          <= '0;
            proto_err_reg       <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_open_reg[b] <= 1'b0;
                bank_row_reg[b]  <= '0;
            end
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;

            if (timer_reg == 16'(T_REFI - 1)) begin
                timer_reg           <= '0;
                refresh_pending_reg <= 1'b1;
            end else begin
                timer_reg <= timer_reg + 16'd1;
                if (do_refresh) begin
                    refresh_pending_reg <= 1'b0;
                end
            end

            if (classify) begin
                req_write_reg <= req_write;
                req_bank_reg  <= addr_bank;
                req_row_reg   <= addr_row;
                req_index_reg <= addr_index;
                if (row_hit) begin
                    if (hits_reg != 16'hFFFF) hits_reg <= hits_reg + 16'd1;
                end else begin
                    if (misses_reg != 16'hFFFF) misses_reg <= misses_reg + 16'd1;
                end
            end

            if (do_refresh) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    bank_open_reg[b] <= 1'b0;
                end
            end else if (do_precharge) begin
                bank_open_reg[req_bank_reg] <= 1'b0;
            end else if (do_activate) begin
                bank_open_reg[req_bank_reg] <= 1'b1;
                bank_row_reg[req_bank_reg]  <= req_row_reg;
            end

            if (capture_read) begin
                mem_rdata_reg <= array_rdata ^ flip_mask;
            end

            if ((mem_read_req && mem_write_req) || drop) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign mem_ready = (state_reg == ST_DONE) ||
                       ((state_reg == ST_IDLE) && !req_present && !refresh_pending_reg);
    assign mem_rdata       = mem_rdata_reg;
    assign stat_row_hits   = hits_reg;
    assign stat_row_misses = misses_reg;
    assign proto_err       = proto_err_reg;
    assign busy            = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_device_responder.sv
// Directed bench for mem_device_responder: latencies per row state, data
// round trip, refresh window, error injection and reset abort.
module tb_mem_device_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic         mem_read_req = 1'b0;
    logic         mem_write_req = 1'b0;
    logic [255:0] mem_wdata = '0;
    logic [255:0] mem_rdata;
    logic         mem_ready;
    logic         inj_err_en = 1'b0;
    logic [7:0]   inj_err_bit = '0;
    logic [15:0]  stat_row_hits, stat_row_misses;
    logic         proto_err, busy;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};

    always #5 clk = ~clk;

    mem_device_responder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_addr        (mem_addr),
        .mem_read_req    (mem_read_req),
        .mem_write_req   (mem_write_req),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready),
        .inj_err_en      (inj_err_en),
        .inj_err_bit     (inj_err_bit),
        .stat_row_hits   (stat_row_hits),
        .stat_row_misses (stat_row_misses),
        .proto_err       (proto_err),
        .busy            (busy)
    );

    task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Presents one request, returns cycles from first presentation to mem_ready
    // (capped at 100), and releases the request after the completion cycle.
    task automatic run_req(input logic [31:0] addr, input logic wr, input logic [255:0] wd,
                           output int lat);
        @(posedge clk); #1;
        mem_addr      = addr;
        mem_read_req  = !wr;
        mem_write_req = wr;
        mem_wdata     = wd;
        lat = 0;
        @(negedge clk);
        while (!mem_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk); #1;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        int ready_seen;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("reset_ready", mem_ready, 1);
        check_value("reset_busy", busy, 0);
        check_value("reset_rdata", mem_rdata, 0);
        check_value("reset_hits", stat_row_hits, 0);
        check_value("reset_misses", stat_row_misses, 0);
        check_value("reset_proto", proto_err, 0);

        run_req(32'h0002_0008, 1'b1, PAT_A5, lat);
        check_value("wr_closed_lat", lat, 5);
        check_value("wr_closed_misses", stat_row_misses, 1);

        run_req(32'h0002_0008, 1'b0, '0, lat);
        check_value("rd_hit_lat", lat, 4);
        check_value("rd_hit_data", mem_rdata, PAT_A5);
        check_value("rd_hit_hits", stat_row_hits, 1);

        run_req(32'h0004_0008, 1'b0, '0, lat);
        check_value("rd_conflict_lat", lat, 10);
        check_value("rd_conflict_data", mem_rdata, PAT_A5);
        check_value("rd_conflict_misses", stat_row_misses, 2);
        check_value("no_proto_err", proto_err, 0);

        // Sit idle until the refresh window opens, then measure it.
        n = 0;
        while (!busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_value("refresh_seen", busy, 1);
        n = 0;
        ready_seen = 0;
        while (busy && n < 100) begin
            if (mem_ready) ready_seen++;
            @(negedge clk);
            n++;
        end
        check_value("refresh_len", n, 8);
        check_value("refresh_ready_low", ready_seen, 0);

        run_req(32'h0004_0008, 1'b0, '0, lat);
        check_value("post_refresh_lat", lat, 7);
        check_value("post_refresh_data", mem_rdata, PAT_A5);
        check_value("post_refresh_misses", stat_row_misses, 3);

        inj_err_en  = 1'b1;
        inj_err_bit = 8'd0;
        run_req(32'h0004_0008, 1'b0, '0, lat);
        inj_err_en  = 1'b0;
        check_value("inj_lat", lat, 4);
        check_value("inj_data", mem_rdata, PAT_A5 ^ 256'd1);
        run_req(32'h0004_0008, 1'b0, '0, lat);
        check_value("reread_data", mem_rdata, PAT_A5);
        check_value("reread_hits", stat_row_hits, 3);

        // Both request lines high to bank 1 (closed): reset hits during ACCESS.
        @(posedge clk); #1;
        mem_addr      = 32'h0006_2010;
        mem_wdata     = ~PAT_A5;
        mem_read_req  = 1'b1;
        mem_write_req = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_value("both_req_proto", proto_err, 1);
        check_value("midop_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        check_value("rst_busy", busy, 0);
        check_value("rst_proto", proto_err, 0);
        check_value("rst_rdata", mem_rdata, 0);
        check_value("rst_hits", stat_row_hits, 0);
        check_value("rst_misses", stat_row_misses, 0);
        check_value("rst_ready_with_req", mem_ready, 0);
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        #1;
        check_value("rst_ready_idle", mem_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(32'h0006_2010, 1'b0, '0, lat);
        check_value("after_rst_closed_lat", lat, 7);
        check_value("after_rst_misses", stat_row_misses, 1);
        check_value("after_rst_proto", proto_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_device_responder.md
Name: mem_device_responder

Overview:
- Memory-device-side responder for the controller-to-memory interface: accepts single-beat read/write requests on mem_addr/mem_read_req/mem_write_req and completes them with mem_ready.
- Models per-bank open-row state with row-hit, row-closed and row-conflict latencies, plus periodic internal refresh.
- Backs data with an on-chip 256-bit-wide array.
- Serves as the synthesizable memory endpoint for FPGA bring-up and as the reference responder in controller verification.

Parameters:
- AW, 8: storage index width; array holds 2**AW words of 256 bits.
- T_RCD, 3: activate-to-access cycles.
- T_CL, 4: read access cycles.
- T_WR, 2: write access cycles.
- T_RP, 3: precharge cycles.
- T_RFC, 8: refresh busy cycles.
- T_REFI, 512: cycles between refresh requests.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_addr  in  32  request address: row=[31:17], bank=[16:13], col=[12:3], [2:0] ignored
- mem_read_req  in  1  read request, held until mem_ready
- mem_write_req  in  1  write request, held until mem_ready
- mem_wdata  in  256  write data, stable while mem_write_req is high
- mem_rdata  out  256  read data, valid in the mem_ready cycle that completes a read, held until the next read completes
- mem_ready  out  1  completion strobe, and idle-ready when no request is present
- inj_err_en  in  1  invert one bit of the read data on its way out
- inj_err_bit  in  8  index of the bit to invert
- stat_row_hits  out  16  saturating count of row-hit accesses
- stat_row_misses  out  16  saturating count of closed-row plus conflict accesses
- proto_err  out  1  sticky protocol-violation flag
- busy  out  1  high whenever state is not IDLE

Behaviour:
- One clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state IDLE; all 16 banks closed.
  - mem_rdata=0, stat counters=0, proto_err=0, busy=0, refresh timer=0.
  - mem_ready=1 unless a request is present.
  - Array contents are not reset and are undefined until written.
- States: IDLE, PRECHARGE, ACTIVATE, ACCESS, DONE, REFRESH. A single 16-bit down-counter times PRECHARGE, ACTIVATE, ACCESS and REFRESH.
- mem_ready, combinational:
  - equals (state==DONE), or
  - (state==IDLE and no request present and no refresh pending).
  - It is never high in the first cycle a request is presented.
- IDLE with a request present and no refresh pending: classify on the bank open-row table.
  - Hit (bank open, same row) -> ACCESS.
  - Closed (bank not open) -> ACTIVATE.
  - Conflict (bank open, different row) -> PRECHARGE.
- Phase lengths and transitions:
  - PRECHARGE lasts T_RP cycles -> ACTIVATE.
  - ACTIVATE lasts T_RCD cycles, records the row as open -> ACCESS.
  - ACCESS lasts T_CL cycles (read) or T_WR cycles (write) -> DONE.
  - DONE lasts 1 cycle -> IDLE.
- Latency: mem_ready rises exactly L cycles after the first cycle the request is presented.
  - Hit: L = T_CL (read) or T_WR (write).
  - Closed: L = T_RCD + T_CL, or T_RCD + T_WR.
  - Conflict: L = T_RP + T_RCD + T_CL, or T_RP + T_RCD + T_WR.
- Data handling:
  - Write: array[{bank,col}[AW-1:0]] is updated at the clock edge leaving DONE.
  - Read: mem_rdata is registered at the edge entering DONE.
  - Index aliasing across rows is intended.
- Error injection: if inj_err_en is high in the cycle the read data is captured, the captured mem_rdata has bit inj_err_bit inverted; the array is unchanged.
- Statistics: the hit or miss counter increments once per request, at classification, and saturates at 0xFFFF.
- Refresh:
  - The timer counts every cycle; at T_REFI-1 it sets refresh-pending and wraps to 0.
  - Refresh is entered only from IDLE and takes priority over a request present in the same cycle.
  - REFRESH lasts T_RFC cycles, closes all banks, clears pending, with mem_ready=0.
  - Refresh never interrupts an access.
- Protocol errors (each sets proto_err, sticky until reset):
  - mem_read_req and mem_write_req both high: the request is treated as a write.
  - Request dropped before DONE: return to IDLE next cycle with no array write and no mem_rdata update; rows opened so far stay open.
- A request still high in the cycle after DONE is a new request.
- Reset mid-operation aborts immediately to the reset values; an in-flight write is lost.

Decomposition:
- mem_if_pkg holds:
  - address-field localparams (ROW_LSB=17, BANK_LSB=13, COL_LSB=3, field widths);
  - NUM_BANKS=16;
  - the state enum;
  - the default timing constants, shared with the controller side.
- Sub-module mem_storage_array: 2**AW x 256 single-port synchronous array, with write enable, index and wdata, and registered rdata.

Test Plan:
- After reset, write 256'hA5A5…A5 to 0x0002_0008 (bank 0 closed) -> mem_ready rises 5 cycles after request; stat_row_misses=1.
- Read 0x0002_0008 -> row hit; mem_ready after 4 cycles; mem_rdata=A5…A5; stat_row_hits=1.
- Read 0x0004_0008 (same bank, row 2) -> conflict; mem_ready after 10 cycles; data=A5…A5 (aliased index); stat_row_misses=2.
- Idle across the refresh point, then read 0x0004_0008 -> mem_ready low for 8 refresh cycles, then a closed-row access at 7 cycles.
- Read with inj_err_en=1, inj_err_bit=0 -> mem_rdata bit 0 inverted; immediate re-read with inj_err_en=0 returns the original word.
- Assert both req lines, then pulse rst_n low during ACCESS -> proto_err=1 before reset; after reset all outputs at reset values and the next access to that bank is a closed-row access.
